// File: rtl/bus_port_fifo.sv
// bus_port_fifo: per-device TX/RX packet buffers between a device and the bus arbiter.
// TX drains to the bus via pndng/D_pop/pop; RX takes bus pushes filtered on destination ID.

module bus_port_fifo_q #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic                       i_rd,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_ovf,
    output logic                       o_udf
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_empty;
    logic          w_full;
    logic          w_rd_ok;
    logic          w_wr_ok;

    assign w_empty = r_cnt == '0;
    assign w_full  = r_cnt == CW'(DEPTH);
    assign w_rd_ok = i_rd & ~w_empty;
    // A read in the same cycle frees the slot a write into a full FIFO needs.
    assign w_wr_ok = i_wr & (~w_full | w_rd_ok);
    assign o_ovf   = i_wr & ~w_wr_ok;
    assign o_udf   = i_rd & w_empty;
    assign o_count = r_cnt;
    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_wr_ok);
            r_rd_ptr <= r_rd_ptr + PW'(w_rd_ok);
            r_cnt    <= r_cnt + CW'(w_wr_ok) - CW'(w_rd_ok);
        end
    end
endmodule

module bus_port_fifo #(
    parameter int          pckg_sz   = 16,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dev_wr,
    input  logic [pckg_sz-1:0]         dev_din,
    output logic                       dev_full,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       dev_rd,
    output logic [pckg_sz-1:0]         dev_dout,
    output logic                       dev_valid,
    output logic [$clog2(depth+1)-1:0] tx_count,
    output logic [$clog2(depth+1)-1:0] rx_count,
    output logic                       ovf_err,
    output logic                       udf_err,
    output logic                       addr_err
);
    localparam int CW = $clog2(depth+1);

    logic [7:0] w_dest;
    logic       w_match;
    logic       w_rx_wr;
    logic       w_tx_ovf;
    logic       w_tx_udf;
    logic       w_rx_ovf;
    logic       w_rx_udf;
    logic       r_ovf;
    logic       r_udf;
    logic       r_addr;

    assign w_dest  = D_push[pckg_sz-1 -: 8];
    assign w_match = (w_dest == id) || (w_dest == broadcast);
    assign w_rx_wr = push & w_match;

    bus_port_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_tx (
        .clk(clk), .reset(reset), .i_wr(dev_wr), .i_rd(pop), .i_din(dev_din),
        .o_dout(D_pop), .o_count(tx_count), .o_ovf(w_tx_ovf), .o_udf(w_tx_udf)
    );

    bus_port_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_rx (
        .clk(clk), .reset(reset), .i_wr(w_rx_wr), .i_rd(dev_rd), .i_din(D_push),
        .o_dout(dev_dout), .o_count(rx_count), .o_ovf(w_rx_ovf), .o_udf(w_rx_udf)
    );

    assign dev_full  = tx_count == CW'(depth);
    assign pndng     = tx_count != '0;
    assign dev_valid = rx_count != '0;
    assign ovf_err   = r_ovf;
    assign udf_err   = r_udf;
    assign addr_err  = r_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
            r_addr <= 1'b0;
        end else begin
            r_ovf  <= r_ovf | w_tx_ovf | w_rx_ovf;
            r_udf  <= r_udf | w_tx_udf | w_rx_udf;
            r_addr <= r_addr | (push & ~w_match);
        end
    end
endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo: directed stimulus with a queue scoreboard; a negedge monitor
// compares every bus pop and device read against the expected packet order.

module tb_bus_port_fifo;
    logic        clk;
    logic        reset;
    logic        dev_wr;
    logic [15:0] dev_din;
    logic        dev_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        dev_rd;
    logic [15:0] dev_dout;
    logic        dev_valid;
    logic [3:0]  tx_count;
    logic [3:0]  rx_count;
    logic        ovf_err;
    logic        udf_err;
    logic        addr_err;

    int n_checks = 0;
    int n_errs   = 0;
    logic [15:0] tx_q [$];
    logic [15:0] rx_q [$];

    bus_port_fifo #(.pckg_sz(16), .depth(8), .id(8'd3), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .dev_wr(dev_wr), .dev_din(dev_din), .dev_full(dev_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
        .dev_rd(dev_rd), .dev_dout(dev_dout), .dev_valid(dev_valid),
        .tx_count(tx_count), .rx_count(rx_count),
        .ovf_err(ovf_err), .udf_err(udf_err), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [15:0] d, input bit exp);
        dev_wr  = 1'b1;
        dev_din = d;
        if (exp) tx_q.push_back(d);
        cyc();
        dev_wr = 1'b0;
    endtask

    task automatic rx_push(input logic [15:0] d, input bit exp);
        push   = 1'b1;
        D_push = d;
        if (exp) rx_q.push_back(d);
        cyc();
        push = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && pop && pndng) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL tx_unexpected: got %h expected none", D_pop);
            end else check("tx_pop", {16'h0, D_pop}, {16'h0, tx_q.pop_front()});
        end
        if (reset && dev_rd && dev_valid) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL rx_unexpected: got %h expected none", dev_dout);
            end else check("rx_read", {16'h0, dev_dout}, {16'h0, rx_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; dev_wr = 1'b0; dev_din = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; dev_rd = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        check("rst_pndng", pndng, 0);
        check("rst_D_pop", D_pop, 0);
        check("rst_dev_valid", dev_valid, 0);
        check("rst_dev_dout", dev_dout, 0);
        check("rst_dev_full", dev_full, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_errs", {ovf_err, udf_err, addr_err}, 0);

        // TX fill, first-word fall-through latency, full
        tx_write(16'h0301, 1);
        check("tx_first_pndng", pndng, 1);
        check("tx_first_D_pop", D_pop, 16'h0301);
        for (int i = 2; i <= 8; i++) tx_write(16'h0300 + 16'(i), 1);
        check("tx_full", dev_full, 1);
        check("tx_count_8", tx_count, 8);
        check("tx_no_ovf", ovf_err, 0);

        // write + pop while full: accepted, no overflow
        pop = 1'b1;
        tx_write(16'h03AA, 1);
        pop = 1'b0;
        check("tx_simul_full_count", tx_count, 8);
        check("tx_simul_full_ovf", ovf_err, 0);

        tx_write(16'h0309, 0);
        check("tx_ovf", ovf_err, 1);
        check("tx_ovf_count", tx_count, 8);

        pop = 1'b1;
        repeat (8) cyc();
        pop = 1'b0;
        check("tx_drain_pndng", pndng, 0);
        check("tx_drain_D_pop", D_pop, 0);
        check("tx_drain_count", tx_count, 0);
        check("tx_drain_udf", udf_err, 0);

        // second pass exercises pointer wrap
        for (int i = 1; i <= 8; i++) tx_write(16'h0320 + 16'(i), 1);
        pop = 1'b1;
        repeat (8) cyc();
        pop = 1'b0;
        check("tx_wrap_count", tx_count, 0);

        // write + pop while empty: write lands, pop is underflow
        pop = 1'b1;
        tx_write(16'h03BB, 1);
        pop = 1'b0;
        check("tx_simul_empty_count", tx_count, 1);
        check("tx_simul_empty_udf", udf_err, 1);
        pop = 1'b1;
        cyc();
        pop = 1'b0;

        // RX destination filter
        rx_push(16'h0311, 1);
        check("rx_valid", dev_valid, 1);
        check("rx_dout", dev_dout, 16'h0311);
        rx_push(16'hFF22, 1);
        check("rx_no_addr_err", addr_err, 0);
        rx_push(16'h0533, 0);
        check("rx_addr_err", addr_err, 1);
        check("rx_count_2", rx_count, 2);
        dev_rd = 1'b1;
        repeat (2) cyc();
        dev_rd = 1'b0;
        check("rx_empty", dev_valid, 0);

        // RX overflow from a clean reset
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check("rst2_errs", {ovf_err, udf_err, addr_err}, 0);
        for (int i = 0; i < 8; i++) rx_push(16'h0350 + 16'(i), 1);
        check("rx_full_count", rx_count, 8);
        check("rx_full_no_ovf", ovf_err, 0);
        rx_push(16'h0358, 0);
        check("rx_ovf", ovf_err, 1);
        check("rx_ovf_count", rx_count, 8);
        dev_rd = 1'b1;
        repeat (8) cyc();
        check("rx_drain_valid", dev_valid, 0);
        check("rx_drain_dout", dev_dout, 0);
        check("rx_no_udf", udf_err, 0);
        cyc();
        dev_rd = 1'b0;
        check("rx_udf", udf_err, 1);

        // mid-operation asynchronous reset
        for (int i = 0; i < 5; i++) tx_write(16'h0360 + 16'(i), 1);
        check("mid_tx_count", tx_count, 5);
        reset = 1'b0;
        #1;
        check("mid_rst_tx_count", tx_count, 0);
        check("mid_rst_pndng", pndng, 0);
        check("mid_rst_D_pop", D_pop, 0);
        check("mid_rst_errs", {ovf_err, udf_err, addr_err}, 0);
        tx_q.delete();
        cyc();
        reset = 1'b1;
        tx_write(16'h0344, 1);
        check("post_rst_pndng", pndng, 1);
        check("post_rst_D_pop", D_pop, 16'h0344);
        pop = 1'b1;
        cyc();
        pop = 1'b0;

        check("tx_q_left", tx_q.size(), 0);
        check("rx_q_left", rx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
